// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: single-clock first-word-fall-through FIFO controller that drives an
// external dual-port RAM macro. Port B is the write port and port A is the read port.
// A 2-entry output buffer hides the macro's 1-cycle read latency, so the pop side can
// sustain one transfer per cycle.
//
// Ports:
//   CLK, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous clear, highest priority
//   push_valid/ready    producer stream, push_data payload
//   pop_valid/ready     consumer stream, pop_data head entry (registered)
//   count               entries pushed and not yet popped, 0..DEPTH
//   ram_AA/ram_CEA      read address / read enable
//   ram_AB/ram_CEB      write address / write enable
//   ram_DB/ram_BWB      write data / bit write enable (all ones)
//   ram_QA              read data, valid the cycle after ram_CEA
module dp_ram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_AA,
  output logic                  ram_CEA,
  output logic [ADDR_WIDTH-1:0] ram_AB,
  output logic                  ram_CEB,
  output logic [DATA_WIDTH-1:0] ram_DB,
  output logic [DATA_WIDTH-1:0] ram_BWB,
  input  logic [DATA_WIDTH-1:0] ram_QA
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic       push_fire;
  logic       pop_fire;
  logic       fetch;
  logic [2:0] ob_occ;
  logic [2:0] ob_limit;
  logic [1:0] ob_rem;

  // Write side
  assign push_ready = rst_n & ~flush & (count_q < DepthCnt);
  assign push_fire  = push_valid & push_ready;
  assign ram_CEB    = push_fire;
  assign ram_AB     = wr_ptr_q;
  assign ram_DB     = push_data;
  assign ram_BWB    = {DATA_WIDTH{1'b1}};

  // Pop side
  assign pop_valid = (ob_cnt_q != 2'd0);
  assign pop_fire  = pop_valid & pop_ready;
  assign pop_data  = ob0_q;
  assign count     = count_q;

  // Fetch only when the buffer slot is guaranteed: held + in-flight - leaving < 2.
  assign ob_occ   = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
  assign ob_limit = 3'd2 + {2'b00, pop_fire};
  assign fetch    = ~flush & (ram_cnt_q != '0) & (ob_occ < ob_limit);
  assign ram_CEA  = fetch;
  assign ram_AA   = fetch_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, push_fire};
    fetch_ptr_d = fetch_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, fetch};
    count_d     = count_q + {{ADDR_WIDTH{1'b0}}, push_fire} - {{ADDR_WIDTH{1'b0}}, pop_fire};
    ram_cnt_d   = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, push_fire} - {{ADDR_WIDTH{1'b0}}, fetch};
    // A new fetch keeps a read outstanding; otherwise the pending one lands now.
    inflight_d  = fetch;

    ob0_d  = ob0_q;
    ob1_d  = ob1_q;
    ob_rem = ob_cnt_q - {1'b0, pop_fire};
    if (pop_fire) begin
      ob0_d = ob1_q;
    end
    // Captured word always goes behind whatever survives the pop.
    if (inflight_q) begin
      if (ob_rem == 2'd0) begin
        ob0_d = ram_QA;
      end else begin
        ob1_d = ram_QA;
      end
    end
    ob_cnt_d = ob_rem + {1'b0, inflight_q};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      count_q     <= '0;
      ram_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      ob_cnt_q    <= 2'd0;
      ob0_q       <= '0;
      ob1_q       <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      count_q     <= '0;
      ram_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      ob_cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      count_q     <= count_d;
      ram_cnt_q   <= ram_cnt_d;
      inflight_q  <= inflight_d;
      ob_cnt_q    <= ob_cnt_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
    end
  end

endmodule
